// File: rtl/banked_byte_memory.sv
// Byte-addressed data/instruction memory built from four 8-bit lane banks, with
// 1-cycle live reads and a start/done/error write handshake. Optional macro: BANKED_MEM_WRITE_PROTECT_EN.
module banked_byte_memory #(
    parameter int          ADDR_BYTES    = 131072,
    parameter string       INIT_FILE     = "",
    parameter logic [31:0] PROTECT_LIMIT = 32'h00001000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [1:0]  write_mode,
    input  logic [7:0]  write_byte,
    input  logic [15:0] write_half_word,
    input  logic [31:0] write_word,
    output logic [7:0]  byte_output,
    output logic [15:0] half_word_output,
    output logic [31:0] word_output,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

    localparam int          DEPTH = ADDR_BYTES / 4;
    localparam int          ROW_W = $clog2(DEPTH);
    localparam logic [32:0] LIMIT = 33'(ADDR_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_COMMIT = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] lat_addr;
    logic [1:0]  lat_mode;
    logic [31:0] lat_data;
    logic [32:0] last_addr;
    logic        reject;

    logic [3:0][7:0] lane_rd;
    logic [31:0]     rd_nxt;
    logic [31:0]     rd_q;

    assign state_dbg = state;

    function automatic logic lane_in_size(input logic [1:0] mode, input logic [1:0] k);
        case (mode)
            2'b01:   lane_in_size = (k == 2'd0);
            2'b10:   lane_in_size = (k <= 2'd1);
            2'b11:   lane_in_size = 1'b1;
            default: lane_in_size = 1'b0;
        endcase
    endfunction

    always_comb begin
        last_addr = {1'b0, lat_addr} + {31'b0, (lat_mode == 2'b11) ? 2'd3 :
                                               (lat_mode == 2'b10) ? 2'd1 : 2'd0};
        reject = last_addr[32] || (last_addr >= LIMIT);
`ifdef BANKED_MEM_WRITE_PROTECT_EN
        // Everything below the limit is program space and never writable.
        reject = reject || (lat_addr < PROTECT_LIMIT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            error    <= 1'b0;
            lat_addr <= '0;
            lat_mode <= '0;
            lat_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    if (write_mode != 2'b00) begin
                        lat_addr <= address;
                        lat_mode <= write_mode;
                        lat_data <= (write_mode == 2'b01) ? {24'b0, write_byte} :
                                    (write_mode == 2'b10) ? {16'b0, write_half_word} :
                                                            write_word;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (reject) begin
                        state <= S_ERR;
                        error <= 1'b1;
                    end else begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    if (write_mode == 2'b00) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (write_mode == 2'b00) begin
                        state <= S_IDLE;
                        error <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    error <= 1'b0;
                end
            endcase
        end
    end

    for (genvar j = 0; j < 4; j++) begin : g_lane
        logic [7:0]       mem [DEPTH];
        logic [1:0]       rd_k;
        logic [32:0]      rd_sum;
        logic             rd_valid;
        logic [ROW_W-1:0] rd_row;
        logic [1:0]       wr_k;
        logic [32:0]      wr_sum;
        logic [ROW_W-1:0] wr_row;
        logic             wr_en;
        logic [7:0]       wr_dat;

        // Each lane finds which access byte k lands on it and derives its own row.
        assign rd_k     = 2'(j) - address[1:0];
        assign rd_sum   = {1'b0, address} + {31'b0, rd_k};
        assign rd_valid = !rd_sum[32] && (rd_sum < LIMIT);
        assign rd_row   = rd_sum[ROW_W+1:2];

        assign wr_k   = 2'(j) - lat_addr[1:0];
        assign wr_sum = {1'b0, lat_addr} + {31'b0, wr_k};
        assign wr_row = wr_sum[ROW_W+1:2];
        assign wr_en  = (state == S_COMMIT) && lane_in_size(lat_mode, wr_k);
        assign wr_dat = lat_data[8*wr_k +: 8];

        always_ff @(posedge clk) begin
            if (wr_en)
                mem[wr_row] <= wr_dat;
        end

        // Forward the committing byte so the cycle after COMMIT already reads it.
        assign lane_rd[j] = !rd_valid ? 8'h00 :
                            (wr_en && (wr_row == rd_row)) ? wr_dat : mem[rd_row];
    end

    always_comb begin
        rd_nxt = '0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] lane;
            lane = address[1:0] + 2'(k);
            rd_nxt[8*k +: 8] = lane_rd[lane];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_q <= '0;
        else
            rd_q <= rd_nxt;
    end

    assign byte_output      = rd_q[7:0];
    assign half_word_output = rd_q[15:0];
    assign word_output      = rd_q;

endmodule

// File: tb/tb_banked_byte_memory.sv
// Directed self-checking bench for banked_byte_memory: handshake latency, misaligned
// lanes, sub-word merges, range boundary, hold/re-arm and reset during COMMIT.
module tb_banked_byte_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [1:0]  write_mode;
    logic [7:0]  write_byte;
    logic [15:0] write_half_word;
    logic [31:0] write_word;
    logic [7:0]  byte_output;
    logic [15:0] half_word_output;
    logic [31:0] word_output;
    logic        done;
    logic        error;
    logic [2:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    banked_byte_memory dut (
        .clk              (clk),
        .rst              (rst),
        .address          (address),
        .write_mode       (write_mode),
        .write_byte       (write_byte),
        .write_half_word  (write_half_word),
        .write_word       (write_word),
        .byte_output      (byte_output),
        .half_word_output (half_word_output),
        .word_output      (word_output),
        .done             (done),
        .error            (error),
        .state_dbg        (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full handshake: launch, check latency of done/error, then drop write_mode.
    task automatic do_write(input string tag, input logic [1:0] mode, input logic [31:0] addr,
                            input logic [31:0] data, input bit exp_err);
        write_mode      = mode;
        address         = addr;
        write_byte      = data[7:0];
        write_half_word = data[15:0];
        write_word      = data;
        tick;
        check_eq({tag, "_flags_p1"}, {30'b0, done, error}, 32'd0);
        tick;
        if (exp_err) begin
            check_eq({tag, "_error_p2"}, {30'b0, done, error}, 32'd1);
        end else begin
            check_eq({tag, "_flags_p2"}, {30'b0, done, error}, 32'd0);
            tick;
            check_eq({tag, "_done_p3"}, {30'b0, done, error}, 32'd2);
        end
        write_mode = 2'b00;
        tick;
        check_eq({tag, "_release"}, {30'b0, done, error}, 32'd0);
    endtask

    task automatic read_at(input logic [31:0] addr);
        address = addr;
        tick;
    endtask

    initial begin
        rst             = 1'b1;
        address         = 32'h0;
        write_mode      = 2'b00;
        write_byte      = 8'h0;
        write_half_word = 16'h0;
        write_word      = 32'h0;
        repeat (3) tick;
        check_eq("reset_word", word_output, 32'h0);
        check_eq("reset_flags", {30'b0, done, error}, 32'd0);
        check_eq("reset_state", {29'b0, state_dbg}, 32'd0);
        rst = 1'b0;
        tick;

        // Aligned word, including read-after-write in the DONE cycle.
        write_mode = 2'b11; address = 32'h100; write_word = 32'hDEADBEEF;
        tick; tick; tick;
        check_eq("aligned_done", {30'b0, done, error}, 32'd2);
        check_eq("aligned_raw", word_output, 32'hDEADBEEF);
        write_mode = 2'b00;
        tick;
        read_at(32'h100);
        check_eq("aligned_word", word_output, 32'hDEADBEEF);
        check_eq("aligned_byte", {24'b0, byte_output}, 32'hEF);
        read_at(32'h101);
        check_eq("aligned_half_101", {16'b0, half_word_output}, 32'hADBE);

        // Misaligned word straddling two rows.
        do_write("pre_200", 2'b11, 32'h200, 32'h55667788, 1'b0);
        do_write("mis_203", 2'b11, 32'h203, 32'h11223344, 1'b0);
        read_at(32'h203);
        check_eq("mis_word_203", word_output, 32'h11223344);
        read_at(32'h206);
        check_eq("mis_byte_206", {24'b0, byte_output}, 32'h11);
        read_at(32'h200);
        check_eq("mis_word_200", word_output, 32'h44667788);

        // Sub-word merge.
        do_write("pre_300", 2'b11, 32'h300, 32'hAAAAAAAA, 1'b0);
        do_write("byte_301", 2'b01, 32'h301, 32'h0000005A, 1'b0);
        read_at(32'h300);
        check_eq("merge_byte", word_output, 32'hAAAA5AAA);
        do_write("half_302", 2'b10, 32'h302, 32'h00001234, 1'b0);
        read_at(32'h300);
        check_eq("merge_half", word_output, 32'h12345AAA);

        // Range boundary.
        do_write("top_ok", 2'b11, 32'h1FFFC, 32'hCAFEF00D, 1'b0);
        do_write("top_bad", 2'b11, 32'h1FFFD, 32'h99999999, 1'b1);
        read_at(32'h1FFFC);
        check_eq("top_unchanged", word_output, 32'hCAFEF00D);
        read_at(32'h1FFFE);
        check_eq("top_partial_read", word_output, 32'h0000CAFE);
        read_at(32'hFFFFFFFF);
        check_eq("wrap_read", word_output, 32'h0);
        do_write("wrap_bad", 2'b10, 32'hFFFFFFFF, 32'h0000BEEF, 1'b1);

        // Hold write_mode for 10 cycles with changing data: one commit only.
        do_write("pre_400", 2'b11, 32'h400, 32'h0, 1'b0);
        do_write("pre_404", 2'b11, 32'h404, 32'h0, 1'b0);
        write_mode = 2'b01; address = 32'h400; write_byte = 8'h11;
        for (int i = 1; i <= 10; i++) begin
            tick;
            write_byte = 8'(i * 7);
            address    = 32'h404;
            if (i >= 3)
                check_eq($sformatf("hold_done_%0d", i), {30'b0, done, error}, 32'd2);
        end
        write_mode = 2'b00;
        tick;
        check_eq("hold_release", {30'b0, done, error}, 32'd0);
        read_at(32'h400);
        check_eq("hold_word_400", word_output, 32'h00000011);
        read_at(32'h404);
        check_eq("hold_word_404", word_output, 32'h0);
        do_write("rearm_401", 2'b01, 32'h401, 32'h00000022, 1'b0);
        read_at(32'h400);
        check_eq("rearm_word", word_output, 32'h00002211);

        // Reset asserted while in COMMIT.
        do_write("pre_500", 2'b11, 32'h500, 32'h01020304, 1'b0);
        write_mode = 2'b11; address = 32'h500; write_word = 32'hA5A5A5A5;
        tick; tick;
        check_eq("commit_state", {29'b0, state_dbg}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_state", {29'b0, state_dbg}, 32'd0);
        check_eq("rst_flags", {30'b0, done, error}, 32'd0);
        write_mode = 2'b00;
        tick;
        rst = 1'b0;
        tick;
        read_at(32'h500);
        check_eq("rst_no_partial", word_output, 32'h01020304);

        // Protection boundary.
`ifdef BANKED_MEM_WRITE_PROTECT_EN
        do_write("prot_ffc", 2'b11, 32'h0FFC, 32'h13579BDF, 1'b1);
        read_at(32'h0FFC);
        check_eq("prot_ffc_data", word_output, 32'h0);
`else
        do_write("prot_ffc", 2'b11, 32'h0FFC, 32'h13579BDF, 1'b0);
        read_at(32'h0FFC);
        check_eq("prot_ffc_data", word_output, 32'h13579BDF);
`endif
        do_write("prot_1000", 2'b11, 32'h1000, 32'h2468ACE0, 1'b0);
        read_at(32'h1000);
        check_eq("prot_1000_data", word_output, 32'h2468ACE0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
